top_fdct_acc_rnd_sat: RTL and testbench



---
 rtl/top_fdct_pkg.sv | 17 +
 rtl/top_fdct_rnd_sat.sv | 37 +++
 rtl/top_fdct_acc_rnd_sat.sv | 109 ++++++++++
 tb/tb_top_fdct_acc_rnd_sat.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_fdct_pkg.sv
// Shared types and defaults for the FDCT coefficient accumulate/round/saturate stage.
package top_fdct_pkg;

    localparam int unsigned PROD_W_DEF = 29;
    localparam int unsigned NTERM_DEF  = 8;
    localparam int unsigned SHIFT_DEF  = 13;
    localparam int unsigned OUT_W_DEF  = 16;

    localparam int OUT_MAX_DEF = (2 ** (OUT_W_DEF - 1)) - 1;
    localparam int OUT_MIN_DEF = -(2 ** (OUT_W_DEF - 1));

    typedef enum logic [0:0] {
        StAcc,
        StHold
    } state_e;

endpackage

// File: rtl/top_fdct_rnd_sat.sv
// Round-half-up, arithmetic shift and saturate an accumulated sum to a signed output word.
module top_fdct_rnd_sat #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned SHIFT = 13,
    parameter int unsigned OUT_W = 16
) (
    input  logic [ACC_W-1:0] sum_i,
    output logic [OUT_W-1:0] data_o,
    output logic             sat_o
);

    localparam logic signed [ACC_W:0] RndBias = (ACC_W + 1)'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W:0] SatMax  = (ACC_W + 1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SatMin  = (ACC_W + 1)'(-(2 ** (OUT_W - 1)));

    logic signed [ACC_W:0] sum_ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shr;

    always_comb begin
        // One guard bit keeps the rounding add from wrapping near the positive limit.
        sum_ext = {sum_i[ACC_W-1], sum_i};
        rnd     = sum_ext + RndBias;
        shr     = rnd >>> SHIFT;
        if (shr > SatMax) begin
            data_o = SatMax[OUT_W-1:0];
            sat_o  = 1'b1;
        end else if (shr < SatMin) begin
            data_o = SatMin[OUT_W-1:0];
            sat_o  = 1'b1;
        end else begin
            data_o = shr[OUT_W-1:0];
            sat_o  = 1'b0;
        end
    end

endmodule

// File: rtl/top_fdct_acc_rnd_sat.sv
// Sums NTERM signed products into one DCT coefficient and presents it rounded and saturated.
module top_fdct_acc_rnd_sat
    import top_fdct_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned NTERM  = NTERM_DEF,
    parameter int unsigned SHIFT  = SHIFT_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF,
    parameter int unsigned ACC_W  = PROD_W + $clog2(NTERM)
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [PROD_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sat,
    output logic [$clog2(NTERM)-1:0]  term_idx
);

    localparam int unsigned IDX_W = $clog2(NTERM);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NTERM - 1);

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]  term_q, term_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_sat_q, out_sat_d;
    logic              out_valid_q, out_valid_d;

    logic [ACC_W-1:0]  in_ext;
    logic [ACC_W-1:0]  sum;
    logic [OUT_W-1:0]  rs_data;
    logic              rs_sat;

    assign in_ext = {{(ACC_W - PROD_W){in_data[PROD_W-1]}}, in_data};
    assign sum    = acc_q + in_ext;

    top_fdct_rnd_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_rnd_sat (
        .sum_i  (sum),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        term_d      = term_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        case (state_q)
            StAcc: begin
                if (in_valid) begin
                    if (term_q == LastIdx) begin
                        acc_d       = '0;
                        term_d      = '0;
                        out_data_d  = rs_data;
                        out_sat_d   = rs_sat;
                        out_valid_d = 1'b1;
                        state_d     = StHold;
                    end else begin
                        acc_d  = sum;
                        term_d = term_q + IDX_W'(1);
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= StAcc;
            acc_q       <= '0;
            term_q      <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            term_q      <= term_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    // in_ready is a pure function of state, so out_ready never reaches it combinationally.
    assign in_ready  = (state_q == StAcc);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;
    assign term_idx  = term_q;

endmodule

// File: tb/tb_top_fdct_acc_rnd_sat.sv
// Directed and randomized checks of the accumulate/round/saturate stage against an arithmetic model.
module tb_top_fdct_acc_rnd_sat;

    localparam int PROD_W = 29;
    localparam int NTERM  = 8;
    localparam int SHIFT  = 13;
    localparam int OUT_W  = 16;
    localparam int IDX_W  = 3;

    logic               ap_clk = 1'b0;
    logic               ap_rst;
    logic [PROD_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_sat;
    logic [IDX_W-1:0]   term_idx;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint prods [NTERM];
    longint got_data;
    longint got_sat;

    top_fdct_acc_rnd_sat dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat),
        .term_idx  (term_idx)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sdata();
        return longint'($signed(out_data));
    endfunction

    // Exact arithmetic: floor((sum + half) / 2^SHIFT), then clamp to the output range.
    function automatic void model(input longint sum, output longint d, output longint s);
        longint num, den, q, hi, lo;
        den = longint'(1) << SHIFT;
        num = sum + den / 2;
        q   = num / den;
        if ((num % den) != 0 && num < 0) q = q - 1;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        if (q > hi) begin
            d = hi; s = 1;
        end else if (q < lo) begin
            d = lo; s = 1;
        end else begin
            d = q; s = 0;
        end
    endfunction

    task automatic fill(input longint v);
        for (int i = 0; i < NTERM; i++) prods[i] = v;
    endtask

    task automatic fill_last(input longint v);
        for (int i = 0; i < NTERM; i++) prods[i] = 0;
        prods[NTERM-1] = v;
    endtask

    task automatic push(input bit gap, output longint sum);
        int bound;
        sum = 0;
        for (int i = 0; i < NTERM; i++) begin
            check("term_idx", longint'(term_idx), i);
            in_data  = PROD_W'(prods[i]);
            in_valid = 1'b1;
            bound = 0;
            while (!in_ready && bound < 20) begin
                step();
                bound++;
            end
            if (!in_ready) check("in_ready_timeout", longint'(in_ready), 1);
            step();
            sum += prods[i];
            if (gap && i < NTERM - 1) begin
                in_valid = 1'b0;
                step();
                check("term_idx_gap", longint'(term_idx), i + 1);
            end
        end
    endtask

    task automatic send_coef(input string tag, input bit gap, input int hold);
        longint sum, ed, es;
        out_ready = (hold == 0);
        push(gap, sum);
        model(sum, ed, es);
        check({tag, "_latency_valid"}, longint'(out_valid), 1);
        check({tag, "_in_ready_low"}, longint'(in_ready), 0);
        check({tag, "_term_wrap"}, longint'(term_idx), 0);
        check({tag, "_data"}, sdata(), ed);
        check({tag, "_sat"}, longint'(out_sat), es);
        got_data = sdata();
        got_sat  = longint'(out_sat);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = PROD_W'($urandom);
            step();
            check({tag, "_hold_valid"}, longint'(out_valid), 1);
            check({tag, "_hold_data"}, sdata(), ed);
            check({tag, "_hold_in_ready"}, longint'(in_ready), 0);
            check({tag, "_hold_term"}, longint'(term_idx), 0);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_post_valid"}, longint'(out_valid), 0);
        check({tag, "_post_in_ready"}, longint'(in_ready), 1);
    endtask

    initial begin
        longint sum;
        logic [PROD_W-1:0] r;
        int mode;

        ap_rst    = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        ap_rst = 1'b0;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", sdata(), 0);
        check("rst_out_sat", longint'(out_sat), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_term_idx", longint'(term_idx), 0);

        fill(8192);
        send_coef("basic", 1'b0, 0);
        check("basic_value", got_data, 8);
        check("basic_sat", got_sat, 0);

        fill_last(4096);
        send_coef("rnd_p4096", 1'b0, 0);
        check("rnd_p4096_value", got_data, 1);
        fill_last(4095);
        send_coef("rnd_p4095", 1'b0, 0);
        check("rnd_p4095_value", got_data, 0);
        fill_last(-4096);
        send_coef("rnd_m4096", 1'b0, 0);
        check("rnd_m4096_value", got_data, 0);
        fill_last(-4097);
        send_coef("rnd_m4097", 1'b0, 0);
        check("rnd_m4097_value", got_data, -1);

        fill(longint'(1) << 27);
        send_coef("sat_pos", 1'b0, 0);
        check("sat_pos_value", got_data, 32767);
        check("sat_pos_flag", got_sat, 1);
        fill(-(longint'(1) << 28));
        send_coef("sat_neg", 1'b0, 0);
        check("sat_neg_value", got_data, -32768);
        check("sat_neg_flag", got_sat, 1);
        fill((longint'(1) << 28) - 1);
        send_coef("sat_edge", 1'b0, 0);
        check("sat_edge_value", got_data, 32767);
        check("sat_edge_flag", got_sat, 1);

        fill(12345);
        send_coef("bp", 1'b0, 5);
        fill(-8192);
        send_coef("bp_next", 1'b0, 0);
        check("bp_next_value", got_data, -8);

        for (int i = 0; i < NTERM; i++) prods[i] = longint'(i + 1) * 1024;
        send_coef("gap1", 1'b1, 0);
        check("gap1_value", got_data, 5);
        for (int i = 0; i < NTERM; i++) prods[i] = longint'(i + 9) * 1024;
        send_coef("gap2", 1'b1, 0);
        check("gap2_value", got_data, 13);

        // Reset after three products discards the partial sum.
        fill(100000);
        for (int i = 0; i < 3; i++) begin
            in_data  = PROD_W'(prods[i]);
            in_valid = 1'b1;
            step();
        end
        check("mid_term_before_rst", longint'(term_idx), 3);
        in_valid = 1'b0;
        ap_rst   = 1'b1;
        step();
        ap_rst = 1'b0;
        check("mid_rst_term", longint'(term_idx), 0);
        check("mid_rst_valid", longint'(out_valid), 0);
        fill(8192);
        send_coef("after_mid_rst", 1'b0, 0);
        check("after_mid_rst_value", got_data, 8);

        // Reset while holding a pending coefficient.
        fill(-5000);
        out_ready = 1'b0;
        push(1'b0, sum);
        in_valid = 1'b0;
        check("hold_before_rst_valid", longint'(out_valid), 1);
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        check("hold_rst_valid", longint'(out_valid), 0);
        check("hold_rst_term", longint'(term_idx), 0);
        check("hold_rst_in_ready", longint'(in_ready), 1);
        check("hold_rst_data", sdata(), 0);
        out_ready = 1'b1;
        step();
        check("hold_rst_no_output", longint'(out_valid), 0);

        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < NTERM; i++) begin
                mode = $urandom_range(0, 2);
                if (mode == 0) begin
                    r = PROD_W'($urandom);
                    prods[i] = longint'($signed(r));
                end else if (mode == 1) begin
                    prods[i] = longint'($urandom_range(0, 65535)) - 32768;
                end else begin
                    prods[i] = (longint'(1) << 28) - longint'($urandom_range(0, 1 << 20));
                    if ($urandom_range(0, 1) == 1) prods[i] = -prods[i];
                end
            end
            send_coef("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
